// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and defaults for the scoreboarded register file.
// Latency: n/a (types only).
// Backpressure: n/a.
package regfile_pkg;

    localparam int RF_DEF_DATA_W = 32;
    localparam int RF_DEF_DEPTH  = 32;

    // Sweep-clear engine states
    typedef enum logic [0:0] {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_t;

    // Read response at the default register width. Modules built with a
    // non-default DATA_W declare an equivalent struct at their own width.
    typedef struct packed {
        logic [RF_DEF_DATA_W-1:0] data;
        logic                     busy;
    } rd_resp_t;

endpackage

// File: rtl/regfile_sb_if.sv
// regfile_sb_if: request/response bundle for the scoreboarded register file.
// Latency: n/a (wiring only).
// Backpressure: none; the master owns en, the slave never stalls.
interface regfile_sb_if #(
    parameter int DATA_W = regfile_pkg::RF_DEF_DATA_W,
    parameter int DEPTH  = regfile_pkg::RF_DEF_DEPTH
) ();
    localparam int ADDR_W = $clog2(DEPTH);

    logic              en;
    logic              rd_req;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic              rbusy1;
    logic              rbusy2;
    logic              rvalid;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              alloc_en;
    logic [ADDR_W-1:0] alloc_addr;
    logic              clr_req;
    logic              clr_busy;

    modport master (
        output en, rd_req, rs1, rs2, wr_en, wr_addr, wr_data,
               alloc_en, alloc_addr, clr_req,
        input  rdata1, rdata2, rbusy1, rbusy2, rvalid, clr_busy
    );

    modport slave (
        input  en, rd_req, rs1, rs2, wr_en, wr_addr, wr_data,
               alloc_en, alloc_addr, clr_req,
        output rdata1, rdata2, rbusy1, rbusy2, rvalid, clr_busy
    );

endinterface

// File: rtl/regfile_sb_scoreboard.sv
// regfile_sb_scoreboard: per-register busy bits with sweep > set > clear priority, two bypassed read taps.
// Latency: taps are combinational; bit updates land on the next clock.
// Backpressure: none; strobes arrive already qualified by enable and FSM state.
module regfile_sb_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH = RF_DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     set_en,
    input  logic [$clog2(DEPTH)-1:0] set_addr,
    input  logic                     clr_en,
    input  logic [$clog2(DEPTH)-1:0] clr_addr,
    input  logic                     sweep_en,
    input  logic [$clog2(DEPTH)-1:0] sweep_addr,
    input  logic [$clog2(DEPTH)-1:0] rs1,
    input  logic [$clog2(DEPTH)-1:0] rs2,
    output logic                     tap1,
    output logic                     tap2
);
    logic [DEPTH-1:0] busy;

    // Busy vector: a completing write clears, a new producer sets (and wins
    // over a same-cycle write), the sweep clears one bit per cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= '0;
        end else if (sweep_en) begin
            busy[sweep_addr] <= 1'b0;
        end else begin
            if (clr_en) busy[clr_addr] <= 1'b0;
            if (set_en) busy[set_addr] <= 1'b1;
        end
    end

    // Read taps: a same-cycle write to the tapped register reports not-busy,
    // unless a same-cycle alloc to that register reissues it.
    always_comb begin
        tap1 = busy[rs1];
        tap2 = busy[rs2];
        if (clr_en && clr_addr == rs1) tap1 = set_en && (set_addr == rs1);
        if (clr_en && clr_addr == rs2) tap2 = set_en && (set_addr == rs2);
    end

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: DEPTH x DATA_W register file, 2 registered read ports, 1 write port, busy scoreboard, sweep-clear.
// Latency: reads return one enabled cycle after rd_req; a sweep takes exactly DEPTH enabled cycles.
// Backpressure: none; en low freezes all state, requests during a sweep are dropped.
// Optional: define REGFILE_ZERO_REG_EN to hardwire register 0 to zero.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W = RF_DEF_DATA_W,
    parameter int DEPTH  = RF_DEF_DEPTH
) (
    input  logic        clk,
    input  logic        reset,
    regfile_sb_if.slave bus
);
    localparam int                ADDR_W    = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              busy;
    } resp_t;

    logic [DATA_W-1:0] rf [DEPTH];
    rf_state_t         state;
    logic [ADDR_W-1:0] cnt;
    logic              clr_busy_q;
    logic              rvalid_q;
    resp_t             resp1_q;
    resp_t             resp2_q;
    resp_t             resp1_d;
    resp_t             resp2_d;

    logic idle;
    logic wr_ok;
    logic alloc_ok;
    logic wr_go;
    logic alloc_go;
    logic rd_go;
    logic sweep_go;
    logic busy1;
    logic busy2;

`ifdef REGFILE_ZERO_REG_EN
    // Register 0 is constant: writes and allocs to it never take effect,
    // so rf[0] and its busy bit stay zero from reset onward.
    assign wr_ok    = (bus.wr_addr != '0);
    assign alloc_ok = (bus.alloc_addr != '0);
`else
    assign wr_ok    = 1'b1;
    assign alloc_ok = 1'b1;
`endif

    assign idle     = (state == RF_IDLE);
    assign wr_go    = bus.en && idle && bus.wr_en && wr_ok;
    assign alloc_go = bus.en && idle && bus.alloc_en && alloc_ok;
    assign rd_go    = idle && bus.rd_req;
    assign sweep_go = bus.en && (state == RF_CLEAR);

    regfile_sb_scoreboard #(
        .DEPTH (DEPTH)
    ) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .set_en     (alloc_go),
        .set_addr   (bus.alloc_addr),
        .clr_en     (wr_go),
        .clr_addr   (bus.wr_addr),
        .sweep_en   (sweep_go),
        .sweep_addr (cnt),
        .rs1        (bus.rs1),
        .rs2        (bus.rs2),
        .tap1       (busy1),
        .tap2       (busy2)
    );

    // Next read response: array contents with write-to-read data bypass.
    always_comb begin
        resp1_d.data = rf[bus.rs1];
        resp1_d.busy = busy1;
        resp2_d.data = rf[bus.rs2];
        resp2_d.busy = busy2;
        if (wr_go && bus.wr_addr == bus.rs1) resp1_d.data = bus.wr_data;
        if (wr_go && bus.wr_addr == bus.rs2) resp2_d.data = bus.wr_data;
`ifdef REGFILE_ZERO_REG_EN
        if (bus.rs1 == '0) resp1_d = '0;
        if (bus.rs2 == '0) resp2_d = '0;
`endif
    end

    // Data array: the sweep owns the write port while clearing.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
        end else if (sweep_go) begin
            rf[cnt] <= '0;
        end else if (wr_go) begin
            rf[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Sweep FSM: one register per enabled cycle, ends on the last index.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RF_IDLE;
            cnt        <= '0;
            clr_busy_q <= 1'b0;
        end else if (bus.en) begin
            case (state)
                RF_IDLE: begin
                    if (bus.clr_req) begin
                        state      <= RF_CLEAR;
                        cnt        <= '0;
                        clr_busy_q <= 1'b1;
                    end
                end
                RF_CLEAR: begin
                    if (cnt == LAST_ADDR) begin
                        state      <= RF_IDLE;
                        cnt        <= '0;
                        clr_busy_q <= 1'b0;
                    end else begin
                        cnt <= cnt + ADDR_W'(1);
                    end
                end
            endcase
        end
    end

    // Read port registers: rvalid pulses per accepted read, data holds otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            resp1_q  <= '0;
            resp2_q  <= '0;
            rvalid_q <= 1'b0;
        end else if (bus.en) begin
            rvalid_q <= rd_go;
            if (rd_go) begin
                resp1_q <= resp1_d;
                resp2_q <= resp2_d;
            end
        end
    end

    assign bus.rdata1   = resp1_q.data;
    assign bus.rbusy1   = resp1_q.busy;
    assign bus.rdata2   = resp2_q.data;
    assign bus.rbusy2   = resp2_q.busy;
    assign bus.rvalid   = rvalid_q;
    assign bus.clr_busy = clr_busy_q;

endmodule
